mano_io_port: RTL and testbench
===============================

# mano_io_port

Pin-side I/O unit for the Mano computer. It implements the Mano programmed-I/O registers INPR/FGI, OUTR/FGO and IEN, plus the interrupt request. Towards the CPU core it serves the INP/OUT/SKI/SKO/ION/IOF instructions. Towards the chip pins (ui_in, uio_in, uo_out) it runs the external host's strobe/acknowledge handshake, which is asynchronous to clk.

## Interface
- SYNC_STAGES, 2, synchronizer depth for host_stb_i and host_ack_i (≥2)
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- host_data_i  in  8  host input byte (ui_in)
- host_stb_i  in  1  async host strobe; rising edge offers host_data_i
- host_ack_i  in  1  async host acknowledge; rising edge consumes out_data_o
- out_data_o  out  8  OUTR contents (uo_out)
- out_valid_o  out  1  OUTR holds a byte not yet acknowledged
- in_busy_o  out  1  input holding buffer full; host must not strobe
- in_ovr_o  out  1  sticky: an input byte was dropped
- cpu_inp_i  in  1  INP executed: consume INPR
- inpr_o  out  8  INPR to AC
- fgi_o  out  1  FGI (SKI)
- cpu_out_i  in  1  OUT executed: load OUTR
- cpu_outr_d_i  in  8  AC[7:0] for OUT
- fgo_o  out  1  FGO (SKO)
- cpu_ion_i / cpu_iof_i  in  1 each  ION / IOF executed
- cpu_int_ack_i  in  1  interrupt cycle taken: clear IEN
- ien_o  out  1  IEN
- irq_o  out  1  IEN & (FGI | FGO), combinational

## Operation
- Reset values:
  - INPR=0, hold buffer empty, FGI=0, in_busy_o=0, in_ovr_o=0.
  - OUTR=0, out_valid_o=0, FGO=1.
  - IEN=0.
  - All synchronizer stages and the edge-detect registers reset to 1. A pin held high through reset is not counted as an edge; only a low→high transition after reset is.
- Input path. Events are stb (synchronized rising edge of host_stb_i) and inp (cpu_inp_i). The path has three states.
  - EMPTY (FGI=0):
    - stb: INPR←data, FGI←1, go to FULL.
    - inp alone: no effect; INPR keeps its value.
  - FULL (FGI=1, hold empty):
    - stb alone: hold←data, go to FULL_HOLD.
    - inp alone: FGI←0, go to EMPTY.
    - stb & inp: INPR←data, stay in FULL.
  - FULL_HOLD (FGI=1, hold full, in_busy_o=1):
    - inp alone: INPR←hold, go to FULL.
    - stb alone: byte dropped, in_ovr_o←1, stay in FULL_HOLD.
    - stb & inp: INPR←hold, hold←data, no overrun, stay in FULL_HOLD.
- Output path. Events are out (cpu_out_i) and ack (synchronized rising edge of host_ack_i).
  - out: OUTR←cpu_outr_d_i, FGO←0, out_valid_o←1. If FGO was already 0, the OUTR value is overwritten and there is no flag change.
  - ack while out_valid_o=1: out_valid_o←0, FGO←1.
  - ack while out_valid_o=0: ignored.
  - out & ack in the same cycle: the out wins. OUTR←new byte, FGO=0, valid=1; the ack is consumed and discarded.
- Interrupt enable:
  - ION: IEN←1.
  - IOF or int_ack: IEN←0.
  - Conflicting requests in the same cycle: the clear wins.
- in_ovr_o clears only on rst.

## Timing
- Host data sampling:
  - host_data_i is sampled in the cycle the synchronized stb edge is detected.
  - The host holds host_data_i stable from the strobe's rising edge until the strobe falls.
- Minimum widths:
  - Strobe and ack high and low widths: ≥ SYNC_STAGES+1 clk.
  - Minimum strobe period: 2·(SYNC_STAGES+1) clk.
- Latencies:
  - Pin rising edge to FGI/INPR update: SYNC_STAGES+1 cycles.
  - Ack pin to FGO=1: SYNC_STAGES+1 cycles.
  - CPU-side events (inp, out, ION/IOF) are registered one cycle after the input is asserted.
  - irq_o follows the flags combinationally.
- in_busy_o is registered and reflects the current state. If the host strobes while in_busy_o=1 and no inp coincides, the byte is dropped.
- Reset mid-handshake: all state returns to reset values. An in-flight byte is lost, and a strobe still high after reset is ignored until it falls and rises again.

## Structure
- Package mano_io_pkg: WORD_W=8 and the input-path state enum {IN_EMPTY, IN_FULL, IN_FULL_HOLD}.
- Sub-module mano_io_sync_edge(SYNC_STAGES): synchronizer chain plus rising-edge pulse, reset-to-1. It is instantiated twice, once for stb and once for ack.
- Top: input state machine, output flag logic, IEN register.

## Test plan
- Reset, then a strobe with 0x5A: FGI=1 and INPR=0x5A after 3 cycles. Assert inp: FGI=0 next cycle, INPR still 0x5A.
- Strobes 0x11, 0x22, 0x33 with no inp: INPR=0x11, in_busy_o=1, in_ovr_o=1. Two inps return 0x22 and then FGI=0; 0x33 is never seen.
- Strobe arriving in the same cycle as inp while in FULL_HOLD (INPR=0x01, hold=0x02, new byte 0x03): INPR=0x02, hold=0x03, in_ovr_o stays 0.
- OUT 0xA5: out_data_o=0xA5, out_valid_o=1, FGO=0. Ack pulse: FGO=1 and valid=0 after 3 cycles. A second ack has no effect.
- Interrupt enable and request:
  - ION, then strobe: irq_o=1 as soon as FGI=1.
  - ION and IOF in the same cycle: IEN=0.
  - int_ack: IEN=0 and irq_o=0.
- Reset asserted with host_stb_i held high: no FGI after release. Drive the strobe low then high: FGI sets.

Source files
------------

// File: rtl/mano_io_pkg.sv
// Shared definitions for the Mano programmed-I/O port: data width and
// the input-path state encoding.
package mano_io_pkg;
  localparam int WORD_W = 8;

  typedef enum logic [1:0] {
    IN_EMPTY     = 2'd0,
    IN_FULL      = 2'd1,
    IN_FULL_HOLD = 2'd2
  } in_state_e;
endpackage

// File: rtl/mano_io_sync_edge.sv
// Synchronizer chain for an asynchronous host pin, followed by a rising-edge
// detector. Every stage resets to 1 so a pin held high through reset is not an edge.
module mano_io_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic rise_pulse
);
  logic [SYNC_STAGES-1:0] sync_r;
  logic                   prev_r;

  // synchronizer shift chain and previous-value register for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_r <= {SYNC_STAGES{1'b1}};
      prev_r <= 1'b1;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], async_in};
      prev_r <= sync_r[SYNC_STAGES-1];
    end
  end

  assign rise_pulse = sync_r[SYNC_STAGES-1] & ~prev_r;
endmodule

// File: rtl/mano_io_port.sv
// Mano computer I/O unit: INPR/FGI with one-byte hold buffer, OUTR/FGO,
// IEN and the interrupt request, bridging to an asynchronous host handshake.
module mano_io_port
  import mano_io_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] host_data_i,
  input  logic              host_stb_i,
  input  logic              host_ack_i,
  output logic [WORD_W-1:0] out_data_o,
  output logic              out_valid_o,
  output logic              in_busy_o,
  output logic              in_ovr_o,
  input  logic              cpu_inp_i,
  output logic [WORD_W-1:0] inpr_o,
  output logic              fgi_o,
  input  logic              cpu_out_i,
  input  logic [WORD_W-1:0] cpu_outr_d_i,
  output logic              fgo_o,
  input  logic              cpu_ion_i,
  input  logic              cpu_iof_i,
  input  logic              cpu_int_ack_i,
  output logic              ien_o,
  output logic              irq_o
);
  logic stb_rise_s;
  logic ack_rise_s;

  in_state_e         state_r, state_nxt_s;
  logic [WORD_W-1:0] inpr_r, inpr_nxt_s;
  logic [WORD_W-1:0] hold_r, hold_nxt_s;
  logic              ovr_r, ovr_nxt_s;
  logic              fgi_r, fgi_nxt_s;
  logic              busy_r, busy_nxt_s;

  logic [WORD_W-1:0] outr_r, outr_nxt_s;
  logic              valid_r, valid_nxt_s;
  logic              fgo_r, fgo_nxt_s;
  logic              ien_r, ien_nxt_s;

  mano_io_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_stb_sync (
    .clk        (clk),
    .rst        (rst),
    .async_in   (host_stb_i),
    .rise_pulse (stb_rise_s)
  );

  mano_io_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_ack_sync (
    .clk        (clk),
    .rst        (rst),
    .async_in   (host_ack_i),
    .rise_pulse (ack_rise_s)
  );

  // input-path next state: a coincident inp frees a slot before the new byte lands
  always_comb begin
    state_nxt_s = state_r;
    inpr_nxt_s  = inpr_r;
    hold_nxt_s  = hold_r;
    ovr_nxt_s   = ovr_r;
    case (state_r)
      IN_EMPTY: begin
        if (stb_rise_s) begin
          inpr_nxt_s  = host_data_i;
          state_nxt_s = IN_FULL;
        end else begin
          state_nxt_s = IN_EMPTY;
        end
      end
      IN_FULL: begin
        if (stb_rise_s && cpu_inp_i) begin
          inpr_nxt_s = host_data_i;
        end else if (stb_rise_s) begin
          hold_nxt_s  = host_data_i;
          state_nxt_s = IN_FULL_HOLD;
        end else if (cpu_inp_i) begin
          state_nxt_s = IN_EMPTY;
        end else begin
          state_nxt_s = IN_FULL;
        end
      end
      IN_FULL_HOLD: begin
        if (cpu_inp_i) begin
          inpr_nxt_s = hold_r;
          if (stb_rise_s) begin
            hold_nxt_s = host_data_i;
          end else begin
            state_nxt_s = IN_FULL;
          end
        end else if (stb_rise_s) begin
          ovr_nxt_s = 1'b1;
        end else begin
          state_nxt_s = IN_FULL_HOLD;
        end
      end
      default: begin
        state_nxt_s = IN_EMPTY;
      end
    endcase
    fgi_nxt_s  = (state_nxt_s != IN_EMPTY);
    busy_nxt_s = (state_nxt_s == IN_FULL_HOLD);
  end

  // output flags and interrupt enable; a new OUT overrides a coincident ack, a clear overrides ION
  always_comb begin
    outr_nxt_s  = outr_r;
    valid_nxt_s = valid_r;
    fgo_nxt_s   = fgo_r;
    ien_nxt_s   = ien_r;
    if (cpu_out_i) begin
      outr_nxt_s  = cpu_outr_d_i;
      valid_nxt_s = 1'b1;
      fgo_nxt_s   = 1'b0;
    end else if (ack_rise_s && valid_r) begin
      valid_nxt_s = 1'b0;
      fgo_nxt_s   = 1'b1;
    end else begin
      valid_nxt_s = valid_r;
    end
    if (cpu_iof_i || cpu_int_ack_i) begin
      ien_nxt_s = 1'b0;
    end else if (cpu_ion_i) begin
      ien_nxt_s = 1'b1;
    end else begin
      ien_nxt_s = ien_r;
    end
  end

  // state and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IN_EMPTY;
      inpr_r  <= {WORD_W{1'b0}};
      hold_r  <= {WORD_W{1'b0}};
      ovr_r   <= 1'b0;
      fgi_r   <= 1'b0;
      busy_r  <= 1'b0;
      outr_r  <= {WORD_W{1'b0}};
      valid_r <= 1'b0;
      fgo_r   <= 1'b1;
      ien_r   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      inpr_r  <= inpr_nxt_s;
      hold_r  <= hold_nxt_s;
      ovr_r   <= ovr_nxt_s;
      fgi_r   <= fgi_nxt_s;
      busy_r  <= busy_nxt_s;
      outr_r  <= outr_nxt_s;
      valid_r <= valid_nxt_s;
      fgo_r   <= fgo_nxt_s;
      ien_r   <= ien_nxt_s;
    end
  end

  assign inpr_o      = inpr_r;
  assign fgi_o       = fgi_r;
  assign in_busy_o   = busy_r;
  assign in_ovr_o    = ovr_r;
  assign out_data_o  = outr_r;
  assign out_valid_o = valid_r;
  assign fgo_o       = fgo_r;
  assign ien_o       = ien_r;
  assign irq_o       = ien_r & (fgi_r | fgo_r);
endmodule

// File: tb/tb_mano_io_port.sv
// Bench for mano_io_port: directed scenarios with literal expectations, then
// randomized host/CPU traffic checked every cycle against a queue-based model.
module tb_mano_io_port;
  localparam int SYNC = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] host_data = 8'h00;
  logic       host_stb = 1'b0;
  logic       host_ack = 1'b0;
  logic       cpu_inp = 1'b0;
  logic       cpu_out = 1'b0;
  logic [7:0] cpu_d = 8'h00;
  logic       cpu_ion = 1'b0;
  logic       cpu_iof = 1'b0;
  logic       cpu_int_ack = 1'b0;

  logic [7:0] out_data, inpr;
  logic       out_valid, in_busy, in_ovr, fgi, fgo, ien, irq;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  mano_io_port #(.SYNC_STAGES(SYNC)) dut (
    .clk           (clk),
    .rst           (rst),
    .host_data_i   (host_data),
    .host_stb_i    (host_stb),
    .host_ack_i    (host_ack),
    .out_data_o    (out_data),
    .out_valid_o   (out_valid),
    .in_busy_o     (in_busy),
    .in_ovr_o      (in_ovr),
    .cpu_inp_i     (cpu_inp),
    .inpr_o        (inpr),
    .fgi_o         (fgi),
    .cpu_out_i     (cpu_out),
    .cpu_outr_d_i  (cpu_d),
    .fgo_o         (fgo),
    .cpu_ion_i     (cpu_ion),
    .cpu_iof_i     (cpu_iof),
    .cpu_int_ack_i (cpu_int_ack),
    .ien_o         (ien),
    .irq_o         (irq)
  );

  // Model: pending input bytes as a queue of at most two (front = INPR),
  // pin sample history to turn a pin rise into an event SYNC+1 edges later.
  logic [7:0] mq[$];
  logic [7:0] m_last = 8'h00;
  bit         m_ovr = 1'b0;
  logic [7:0] m_outr = 8'h00;
  bit         m_valid = 1'b0;
  bit         m_ien = 1'b0;
  bit         sh_stb[SYNC+1];
  bit         sh_ack[SYNC+1];

  task automatic model_edge();
    bit stb_ev, ack_ev;
    stb_ev = sh_stb[SYNC-1] && !sh_stb[SYNC];
    ack_ev = sh_ack[SYNC-1] && !sh_ack[SYNC];
    if (rst) begin
      mq.delete();
      m_last = 8'h00; m_ovr = 1'b0;
      m_outr = 8'h00; m_valid = 1'b0; m_ien = 1'b0;
      for (int i = 0; i <= SYNC; i++) begin
        sh_stb[i] = 1'b1;
        sh_ack[i] = 1'b1;
      end
    end else begin
      if (cpu_inp && mq.size() > 0) m_last = mq.pop_front();
      if (stb_ev) begin
        if (mq.size() < 2) mq.push_back(host_data);
        else m_ovr = 1'b1;
      end
      if (cpu_out) begin
        m_outr = cpu_d;
        m_valid = 1'b1;
      end else if (ack_ev) begin
        m_valid = 1'b0;
      end
      if (cpu_iof || cpu_int_ack) m_ien = 1'b0;
      else if (cpu_ion) m_ien = 1'b1;
      for (int i = SYNC; i > 0; i--) begin
        sh_stb[i] = sh_stb[i-1];
        sh_ack[i] = sh_ack[i-1];
      end
      sh_stb[0] = host_stb;
      sh_ack[0] = host_ack;
    end
  endtask

  task automatic cmp(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #2;
  endtask

  task automatic cyc(input int n);
    repeat (n) step();
  endtask

  task automatic strobe(input logic [7:0] d);
    host_data = d;
    host_stb = 1'b1;
    cyc(3);
    host_stb = 1'b0;
    cyc(3);
  endtask

  // per-cycle comparison of every output against the model
  initial begin
    bit m_fgi, m_fgo;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        m_fgi = (mq.size() > 0);
        m_fgo = !m_valid;
        cmp("m_inpr", inpr, (mq.size() > 0) ? mq[0] : m_last);
        cmp("m_fgi", {7'd0, fgi}, {7'd0, m_fgi});
        cmp("m_busy", {7'd0, in_busy}, {7'd0, mq.size() == 2});
        cmp("m_ovr", {7'd0, in_ovr}, {7'd0, m_ovr});
        cmp("m_outr", out_data, m_outr);
        cmp("m_valid", {7'd0, out_valid}, {7'd0, m_valid});
        cmp("m_fgo", {7'd0, fgo}, {7'd0, m_fgo});
        cmp("m_ien", {7'd0, ien}, {7'd0, m_ien});
        cmp("m_irq", {7'd0, irq}, {7'd0, m_ien & (m_fgi | m_fgo)});
      end
    end
  end

  initial begin
    int stb_cnt, ack_cnt;
    for (int i = 0; i <= SYNC; i++) begin
      sh_stb[i] = 1'b1;
      sh_ack[i] = 1'b1;
    end
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    chk_en = 1'b1;
    cyc(1);
    cmp("rst_inpr", inpr, 8'h00);
    cmp("rst_fgi", {7'd0, fgi}, 8'h00);
    cmp("rst_fgo", {7'd0, fgo}, 8'h01);
    cmp("rst_valid", {7'd0, out_valid}, 8'h00);
    cmp("rst_ien", {7'd0, ien}, 8'h00);

    // single byte in, then consumed
    host_data = 8'h5A;
    host_stb = 1'b1;
    cyc(3);
    cmp("in1_fgi", {7'd0, fgi}, 8'h01);
    cmp("in1_inpr", inpr, 8'h5A);
    host_stb = 1'b0;
    cyc(3);
    cpu_inp = 1'b1; step(); cpu_inp = 1'b0;
    cmp("inp1_fgi", {7'd0, fgi}, 8'h00);
    cmp("inp1_inpr", inpr, 8'h5A);

    // three bytes: hold fills, third is dropped
    strobe(8'h11); strobe(8'h22); strobe(8'h33);
    cmp("ovr_inpr", inpr, 8'h11);
    cmp("ovr_busy", {7'd0, in_busy}, 8'h01);
    cmp("ovr_flag", {7'd0, in_ovr}, 8'h01);
    cpu_inp = 1'b1; step(); cpu_inp = 1'b0;
    cmp("ovr_inp1", inpr, 8'h22);
    cmp("ovr_fgi1", {7'd0, fgi}, 8'h01);
    cpu_inp = 1'b1; step(); cpu_inp = 1'b0;
    cmp("ovr_fgi2", {7'd0, fgi}, 8'h00);
    cmp("ovr_inp2", inpr, 8'h22);

    // strobe coinciding with inp while hold is full
    rst = 1'b1; step(); rst = 1'b0; step();
    strobe(8'h01); strobe(8'h02);
    host_data = 8'h03; host_stb = 1'b1;
    cyc(2);
    cpu_inp = 1'b1; step(); cpu_inp = 1'b0;
    cmp("coin_inpr", inpr, 8'h02);
    cmp("coin_busy", {7'd0, in_busy}, 8'h01);
    cmp("coin_ovr", {7'd0, in_ovr}, 8'h00);
    host_stb = 1'b0; cyc(3);
    cpu_inp = 1'b1; step(); cpu_inp = 1'b0;
    cmp("coin_next", inpr, 8'h03);

    // OUT and ack handshake
    cpu_out = 1'b1; cpu_d = 8'hA5; step(); cpu_out = 1'b0;
    cmp("out_data", out_data, 8'hA5);
    cmp("out_valid", {7'd0, out_valid}, 8'h01);
    cmp("out_fgo", {7'd0, fgo}, 8'h00);
    host_ack = 1'b1; cyc(3);
    cmp("ack_fgo", {7'd0, fgo}, 8'h01);
    cmp("ack_valid", {7'd0, out_valid}, 8'h00);
    host_ack = 1'b0; cyc(3);
    host_ack = 1'b1; cyc(3); host_ack = 1'b0; cyc(3);
    cmp("ack2_fgo", {7'd0, fgo}, 8'h01);
    cmp("ack2_data", out_data, 8'hA5);

    // interrupt enable and request
    rst = 1'b1; step(); rst = 1'b0; step();
    cpu_out = 1'b1; cpu_d = 8'h3C; step(); cpu_out = 1'b0;
    cpu_ion = 1'b1; step(); cpu_ion = 1'b0;
    cmp("ion_ien", {7'd0, ien}, 8'h01);
    cmp("ion_irq0", {7'd0, irq}, 8'h00);
    host_data = 8'h77; host_stb = 1'b1; cyc(3);
    cmp("ion_irq1", {7'd0, irq}, 8'h01);
    host_stb = 1'b0; cyc(3);
    cpu_ion = 1'b1; cpu_iof = 1'b1; step(); cpu_ion = 1'b0; cpu_iof = 1'b0;
    cmp("ioniof_ien", {7'd0, ien}, 8'h00);
    cpu_ion = 1'b1; step(); cpu_ion = 1'b0;
    cpu_int_ack = 1'b1; step(); cpu_int_ack = 1'b0;
    cmp("intack_ien", {7'd0, ien}, 8'h00);
    cmp("intack_irq", {7'd0, irq}, 8'h00);

    // strobe held high through reset is not an edge
    rst = 1'b1; host_stb = 1'b1; host_data = 8'hC3; cyc(2);
    rst = 1'b0; cyc(6);
    cmp("rsthi_fgi", {7'd0, fgi}, 8'h00);
    host_stb = 1'b0; cyc(3);
    host_stb = 1'b1; cyc(3);
    cmp("rsthi_fgi2", {7'd0, fgi}, 8'h01);
    cmp("rsthi_inpr", inpr, 8'hC3);
    host_stb = 1'b0; cyc(3);

    // randomized traffic with legal pin widths
    stb_cnt = 3;
    ack_cnt = 5;
    for (int c = 0; c < 5000; c++) begin
      rst = ($urandom_range(0, 699) == 0);
      stb_cnt--;
      if (stb_cnt == 0) begin
        if (!host_stb) begin
          host_data = 8'($urandom);
          host_stb = 1'b1;
          stb_cnt = $urandom_range(3, 6);
        end else begin
          host_stb = 1'b0;
          stb_cnt = $urandom_range(3, 9);
        end
      end
      ack_cnt--;
      if (ack_cnt == 0) begin
        host_ack = !host_ack;
        ack_cnt = $urandom_range(3, 10);
      end
      cpu_inp = ($urandom_range(0, 3) == 0);
      cpu_out = ($urandom_range(0, 6) == 0);
      cpu_d = 8'($urandom);
      cpu_ion = ($urandom_range(0, 9) == 0);
      cpu_iof = ($urandom_range(0, 19) == 0);
      cpu_int_ack = ($urandom_range(0, 19) == 0);
      step();
    end
    rst = 1'b0;
    cpu_inp = 1'b0; cpu_out = 1'b0; cpu_ion = 1'b0; cpu_iof = 1'b0; cpu_int_ack = 1'b0;
    cyc(2);
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
